// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round scheduler.
// Holds the FSM state encoding, the LFSR seed/taps and a counter-width helper.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      SHOW,
      MISS,
      OVER
   } state_t;

   // Galois right-shift form of x^8 + x^6 + x^5 + x^4 + 1
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Galois LFSR, seeded on reset; exposes the low bits used for mole selection.
module mole_lfsr
   import mole_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [2:0] rnd
);

   logic [7:0] lfsr_reg;
   logic [7:0] lfsr_next;

   always_comb begin
      lfsr_next = lfsr_reg;
      if (en) begin
         lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 8'h00);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_reg <= LFSR_SEED;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   assign rnd = lfsr_reg[2:0];

endmodule

// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: picks the next mole, times gap/hit windows,
// judges presses and tracks score and lives. All outputs are registered.
module mole_round_scheduler
   import mole_pkg::*;
#(
   parameter int NUM_MOLES = 8,
   parameter int TICK_DIV  = 1000,
   parameter int WIN_INIT  = 1000,
   parameter int WIN_MIN   = 200,
   parameter int WIN_STEP  = 50,
   parameter int GAP_TICKS = 300,
   parameter int LIVES     = 3,
   parameter int SCORE_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_MOLES-1:0] btn_press,
   output logic [NUM_MOLES-1:0] mole_oh,
   output logic [SCORE_W-1:0]   score,
   output logic [1:0]           lives,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic                 game_over,
   output logic                 busy
);

   localparam int TICK_W = cnt_width(TICK_DIV - 1);
   localparam int GAP_W  = cnt_width(GAP_TICKS - 1);
   localparam int WIN_W  = cnt_width(WIN_INIT);

   localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_TICKS - 1);
   localparam logic [WIN_W-1:0]  WIN_INIT_V = WIN_W'(WIN_INIT);
   localparam logic [WIN_W-1:0]  WIN_MIN_V  = WIN_W'(WIN_MIN);
   localparam logic [WIN_W-1:0]  WIN_STEP_V = WIN_W'(WIN_STEP);
   localparam logic [1:0]        LIVES_V    = 2'(LIVES);

   state_t                 state_reg, state_next;
   logic [TICK_W-1:0]      tick_cnt_reg, tick_cnt_next;
   logic [GAP_W-1:0]       gap_cnt_reg, gap_cnt_next;
   logic [WIN_W-1:0]       countdown_reg, countdown_next;
   logic [WIN_W-1:0]       window_reg, window_next;
   logic [2:0]             prev_idx_reg, prev_idx_next;
   logic [NUM_MOLES-1:0]   mole_reg, mole_next;
   logic [SCORE_W-1:0]     score_reg, score_next;
   logic [1:0]             lives_reg, lives_next;
   logic                   hit_reg, hit_next;
   logic                   miss_reg, miss_next;
   logic                   over_reg, over_next;
   logic                   busy_reg, busy_next;

   logic                   tick;
   logic [2:0]             lfsr_low;
   logic [2:0]             pick_raw;
   logic [2:0]             pick_idx;
   logic [NUM_MOLES-1:0]   pick_oh;

   mole_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .rnd   (lfsr_low)
   );

   assign tick = (tick_cnt_reg == TICK_LAST);

   // Step past the previous mole so the same one never lights twice in a row.
   always_comb begin
      pick_raw = 3'(32'(lfsr_low) % NUM_MOLES);
      pick_idx = pick_raw;
      if (pick_raw == prev_idx_reg) begin
         pick_idx = 3'((32'(pick_raw) + 1) % NUM_MOLES);
      end
   end

   for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_pick_dec
      assign pick_oh[gi] = (pick_idx == 3'(gi));
   end

   always_comb begin
      state_next     = state_reg;
      gap_cnt_next   = gap_cnt_reg;
      countdown_next = countdown_reg;
      window_next    = window_reg;
      prev_idx_next  = prev_idx_reg;
      mole_next      = mole_reg;
      score_next     = score_reg;
      lives_next     = lives_reg;
      hit_next       = 1'b0;
      miss_next      = 1'b0;

      case (state_reg)
         IDLE, OVER: begin
            mole_next = '0;
            if (start) begin
               state_next   = GAP;
               gap_cnt_next = '0;
               score_next   = '0;
               lives_next   = LIVES_V;
               window_next  = WIN_INIT_V;
            end
         end
         GAP: begin
            mole_next = '0;
            if (tick) begin
               if (gap_cnt_reg == GAP_LAST) begin
                  state_next     = SHOW;
                  gap_cnt_next   = '0;
                  mole_next      = pick_oh;
                  prev_idx_next  = pick_idx;
                  countdown_next = window_reg;
               end else begin
                  gap_cnt_next = gap_cnt_reg + 1'b1;
               end
            end
         end
         SHOW: begin
            // A press outranks expiry landing in the same cycle.
            if (btn_press == mole_reg) begin
               state_next   = GAP;
               gap_cnt_next = '0;
               mole_next    = '0;
               hit_next     = 1'b1;
               if (score_reg != '1) begin
                  score_next = score_reg + 1'b1;
               end
               if (32'(window_reg) >= WIN_MIN + WIN_STEP) begin
                  window_next = window_reg - WIN_STEP_V;
               end else begin
                  window_next = WIN_MIN_V;
               end
            end else if ((btn_press != '0) || (tick && (countdown_reg == WIN_W'(1)))) begin
               state_next = MISS;
               mole_next  = '0;
               miss_next  = 1'b1;
               lives_next = lives_reg - 1'b1;
            end else if (tick) begin
               countdown_next = countdown_reg - 1'b1;
            end
         end
         MISS: begin
            mole_next    = '0;
            gap_cnt_next = '0;
            state_next   = (lives_reg == 2'd0) ? OVER : GAP;
         end
         default: begin
            state_next = IDLE;
            mole_next  = '0;
         end
      endcase

      tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
      if (((state_next == GAP) || (state_next == SHOW)) && (state_next != state_reg)) begin
         tick_cnt_next = '0;
      end

      busy_next = (state_next == GAP) || (state_next == SHOW) || (state_next == MISS);
      over_next = (state_next == OVER);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         tick_cnt_reg  <= '0;
         gap_cnt_reg   <= '0;
         countdown_reg <= '0;
         window_reg    <= WIN_INIT_V;
         prev_idx_reg  <= '0;
         mole_reg      <= '0;
         score_reg     <= '0;
         lives_reg     <= LIVES_V;
         hit_reg       <= 1'b0;
         miss_reg      <= 1'b0;
         over_reg      <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         tick_cnt_reg  <= tick_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         countdown_reg <= countdown_next;
         window_reg    <= window_next;
         prev_idx_reg  <= prev_idx_next;
         mole_reg      <= mole_next;
         score_reg     <= score_next;
         lives_reg     <= lives_next;
         hit_reg       <= hit_next;
         miss_reg      <= miss_next;
         over_reg      <= over_next;
         busy_reg      <= busy_next;
      end
   end

   assign mole_oh    = mole_reg;
   assign score      = score_reg;
   assign lives      = lives_reg;
   assign hit_pulse  = hit_reg;
   assign miss_pulse = miss_reg;
   assign game_over  = over_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with short sim timings
// (TICK_DIV=4, WIN_INIT=10, WIN_MIN=6, WIN_STEP=2, GAP_TICKS=3, LIVES=3).
module tb_mole_round_scheduler;

   localparam int NM = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [NM-1:0] btn_press = '0;
   logic [NM-1:0] mole_oh;
   logic [7:0]    score;
   logic [1:0]    lives;
   logic          hit_pulse, miss_pulse, game_over, busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference LFSR; m_used is the value the DUT saw before the latest edge.
   logic [7:0] m_lfsr = 8'hA5;
   logic [7:0] m_used = 8'hA5;
   int         m_prev_idx = 0;

   always #5 clk = ~clk;

   mole_round_scheduler #(
      .NUM_MOLES (NM),
      .TICK_DIV  (4),
      .WIN_INIT  (10),
      .WIN_MIN   (6),
      .WIN_STEP  (2),
      .GAP_TICKS (3),
      .LIVES     (3),
      .SCORE_W   (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .btn_press  (btn_press),
      .mole_oh    (mole_oh),
      .score      (score),
      .lives      (lives),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .game_over  (game_over),
      .busy       (busy)
   );

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      logic [7:0] n;
      n = {1'b0, s[7:1]};
      if (s[0]) n = n ^ 8'b1011_1000;
      return n;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_lfsr <= 8'hA5;
         m_used <= 8'hA5;
      end else begin
         m_used <= m_lfsr;
         m_lfsr <= lfsr_step(m_lfsr);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Waits for a mole to light, counting dark cycles, and checks which one lit.
   task automatic wait_mole(input string tag, output int dark);
      int idx;
      dark = 0;
      while ((mole_oh == '0) && (dark < 200)) begin
         dark++;
         @(negedge clk);
      end
      idx = int'(m_used[2:0]) % NM;
      if (idx == m_prev_idx) idx = (idx + 1) % NM;
      m_prev_idx = idx;
      check_val(tag, 32'(mole_oh), 32'(1) << idx);
      $display("round %s: mole=%b dark=%0d score=%0d lives=%0d", tag, mole_oh, dark, score, lives);
   endtask

   task automatic wait_lit(output int lit);
      lit = 0;
      while ((mole_oh != '0) && (lit < 200)) begin
         lit++;
         @(negedge clk);
      end
   endtask

   task automatic press(input logic [NM-1:0] b);
      btn_press = b;
      @(negedge clk);
      btn_press = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int            d;
      int            lit;
      int            repeats;
      logic [NM-1:0] oh;
      logic [NM-1:0] last_oh;
      logic [NM-1:0] seen;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_mole", 32'(mole_oh), 0);
      check_val("rst_score", 32'(score), 0);
      check_val("rst_lives", 32'(lives), 3);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_over", 32'(game_over), 0);
      check_val("rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Game 1: first mole after 12 dark clocks, then a hit
      wait_mole("g1r1", d);
      check_val("g1r1_dark", d, 12);
      check_val("g1r1_busy", 32'(busy), 1);
      check_val("g1r1_lives", 32'(lives), 3);
      press(mole_oh);
      check_val("hit_pulse", 32'(hit_pulse), 1);
      check_val("hit_score", 32'(score), 1);
      check_val("hit_mole_clear", 32'(mole_oh), 0);
      check_val("hit_no_miss", 32'(miss_pulse), 0);

      // Window now 8 ticks = 32 clocks
      wait_mole("g1r2", d);
      check_val("g1r2_dark", d, 12);
      wait_lit(lit);
      check_val("win8_lit", lit, 32);
      check_val("tmo_miss", 32'(miss_pulse), 1);
      check_val("tmo_lives", 32'(lives), 2);
      check_val("tmo_score", 32'(score), 1);

      wait_mole("g1r3", d);
      check_val("g1r3_dark", d, 13);
      press(mole_oh);
      for (int r = 0; r < 3; r++) begin
         wait_mole("g1_hit", d);
         press(mole_oh);
      end
      check_val("g1_score5", 32'(score), 5);

      // Window clamped at 6 ticks = 24 clocks
      wait_mole("g1r7", d);
      wait_lit(lit);
      check_val("floor_lit", lit, 24);
      check_val("floor_lives", 32'(lives), 1);

      // Press on the exact expiry cycle is a hit
      wait_mole("g1r8", d);
      oh = mole_oh;
      repeat (23) @(negedge clk);
      check_val("expiry_still_lit", 32'(mole_oh), 32'(oh));
      press(oh);
      check_val("expiry_hit", 32'(hit_pulse), 1);
      check_val("expiry_no_miss", 32'(miss_pulse), 0);
      check_val("expiry_score", 32'(score), 6);
      check_val("expiry_lives", 32'(lives), 1);

      // start while busy is ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_mole("g1r9", d);
      check_val("busy_start_dark", d, 11);
      check_val("busy_start_score", 32'(score), 6);
      check_val("busy_start_lives", 32'(lives), 1);

      // Reset mid-SHOW
      rst_n = 1'b0;
      m_prev_idx = 0;
      @(negedge clk);
      check_val("midrst_mole", 32'(mole_oh), 0);
      check_val("midrst_busy", 32'(busy), 0);
      check_val("midrst_score", 32'(score), 0);
      check_val("midrst_lives", 32'(lives), 3);
      rst_n = 1'b1;
      @(negedge clk);

      // Game 2: hit, wrong button, double press, timeout -> OVER
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_mole("g2r1", d);
      check_val("g2r1_dark", d, 12);
      press(mole_oh);
      check_val("g2_score1", 32'(score), 1);

      wait_mole("g2r2", d);
      oh = mole_oh;
      press({oh[NM-2:0], oh[NM-1]});
      check_val("wrong_miss", 32'(miss_pulse), 1);
      check_val("wrong_no_hit", 32'(hit_pulse), 0);
      check_val("wrong_mole_clear", 32'(mole_oh), 0);
      check_val("wrong_lives", 32'(lives), 2);
      @(negedge clk);
      check_val("miss_single", 32'(miss_pulse), 0);
      check_val("miss_then_busy", 32'(busy), 1);

      wait_mole("g2r3", d);
      oh = mole_oh;
      press(oh | {oh[NM-2:0], oh[NM-1]});
      check_val("multi_miss", 32'(miss_pulse), 1);
      check_val("multi_lives", 32'(lives), 1);

      wait_mole("g2r4", d);
      wait_lit(lit);
      check_val("g2_win8_lit", lit, 32);
      check_val("last_miss", 32'(miss_pulse), 1);
      check_val("last_lives", 32'(lives), 0);
      @(negedge clk);
      check_val("over_flag", 32'(game_over), 1);
      check_val("over_busy", 32'(busy), 0);
      check_val("over_score", 32'(score), 1);
      check_val("over_mole", 32'(mole_oh), 0);
      press('1);
      check_val("over_press_score", 32'(score), 1);
      check_val("over_press_pulses", 32'({hit_pulse, miss_pulse}), 0);
      check_val("over_held", 32'(game_over), 1);

      // Game 3 from OVER: timeout at full window, then 200 auto-hit rounds
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("g3_over_clear", 32'(game_over), 0);
      check_val("g3_busy", 32'(busy), 1);
      check_val("g3_lives", 32'(lives), 3);
      check_val("g3_score", 32'(score), 0);
      wait_mole("g3r1", d);
      last_oh = mole_oh;
      seen = mole_oh;
      wait_lit(lit);
      check_val("win10_lit", lit, 40);
      check_val("win10_lives", 32'(lives), 2);

      repeats = 0;
      for (int r = 0; r < 200; r++) begin
         wait_mole("auto", d);
         if (mole_oh == last_oh) repeats++;
         last_oh = mole_oh;
         seen = seen | mole_oh;
         press(mole_oh);
      end
      check_val("no_repeat", repeats, 0);
      check_val("all_seen", 32'(seen), 32'hFF);
      check_val("auto_score", 32'(score), 200);
      check_val("auto_lives", 32'(lives), 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
